// File: rtl/alu_pkg.sv
// Shared definitions for the ALU share arbiter: ALU opcodes, default widths
// and the arbiter FSM state type.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W   = 4;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/alu_rsp_slot.sv
// One-entry valid/ready response buffer holding an ALU result, zero flag and tag.
// A load in the same cycle as a drain refills the slot without a bubble.
module alu_rsp_slot #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] out_i,
  input  logic              zero_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic              rsp_ready_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_out_o,
  output logic              rsp_zero_o,
  output logic [TAG_W-1:0]  rsp_tag_o,
  output logic              free_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              zero_q, zero_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

  assign free_o = !valid_q || rsp_ready_i;

  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    zero_d  = zero_q;
    tag_d   = tag_q;
    if (load_i) begin
      valid_d = 1'b1;
      out_d   = out_i;
      zero_d  = zero_i;
      tag_d   = tag_i;
    end else if (valid_q && rsp_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      tag_q   <= tag_d;
    end
  end

  assign rsp_valid_o = valid_q;
  assign rsp_out_o   = out_q;
  assign rsp_zero_o  = zero_q;
  assign rsp_tag_o   = tag_q;

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between the EX
// stage (port 0) and the branch/address helper (port 1); MULT holds the ALU.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W      = ALU_DATA_W,
  parameter int OP_W        = ALU_OP_W,
  parameter int TAG_W       = 2,
  parameter int MULT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [TAG_W-1:0]  req0_tag,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_out,
  output logic              rsp0_zero,
  output logic [TAG_W-1:0]  rsp0_tag,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_out,
  output logic              rsp1_zero,
  output logic [TAG_W-1:0]  rsp1_tag,

  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero
);

  localparam bit MULT_HOLD = (MULT_CYCLES > 1);
  localparam int CNT_W     = (MULT_CYCLES > 2) ? $clog2(MULT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (MULT_CYCLES > 1) ? CNT_W'(MULT_CYCLES - 2) : '0;
  localparam logic [OP_W-1:0]  MULT_OP  = OP_W'(OP_MULT);

  // Per-port views so arbitration and slots can be indexed by port number.
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_ready;
  logic [1:0]        rsp_valid;
  logic [1:0]        slot_free;
  logic [1:0]        elig;
  logic [1:0]        load;
  logic [OP_W-1:0]   req_op  [2];
  logic [DATA_W-1:0] req_a   [2];
  logic [DATA_W-1:0] req_b   [2];
  logic [TAG_W-1:0]  req_tag [2];
  logic [DATA_W-1:0] slot_out  [2];
  logic              slot_zero [2];
  logic [TAG_W-1:0]  slot_tag  [2];

  assign req_valid  = {req1_valid, req0_valid};
  assign rsp_ready  = {rsp1_ready, rsp0_ready};
  assign req_op[0]  = req0_op;
  assign req_op[1]  = req1_op;
  assign req_a[0]   = req0_a;
  assign req_a[1]   = req1_a;
  assign req_b[0]   = req0_b;
  assign req_b[1]   = req1_b;
  assign req_tag[0] = req0_tag;
  assign req_tag[1] = req1_tag;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic [OP_W-1:0]   lat_op_q, lat_op_d;
  logic [DATA_W-1:0] lat_a_q, lat_a_d;
  logic [DATA_W-1:0] lat_b_q, lat_b_d;
  logic [TAG_W-1:0]  lat_tag_q, lat_tag_d;

  logic              gnt_valid;
  logic              gnt_idx;
  logic [TAG_W-1:0]  load_tag;

  assign elig = req_valid & slot_free;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    lat_op_d  = lat_op_q;
    lat_a_d   = lat_a_q;
    lat_b_d   = lat_b_q;
    lat_tag_d = lat_tag_q;
    gnt_valid = 1'b0;
    gnt_idx   = 1'b0;
    load      = 2'b00;
    load_tag  = '0;
    alu_op    = '0;
    alu_a     = '0;
    alu_b     = '0;

    case (state_q)
      IDLE: begin
        // No grant is visible while reset is held, even with requests pending.
        if (rst_n) begin
          if (elig[0] && elig[1]) begin
            gnt_valid = 1'b1;
            gnt_idx   = rr_q;
          end else if (elig[0]) begin
            gnt_valid = 1'b1;
            gnt_idx   = 1'b0;
          end else if (elig[1]) begin
            gnt_valid = 1'b1;
            gnt_idx   = 1'b1;
          end
        end
        if (gnt_valid) begin
          rr_d   = ~gnt_idx;
          alu_op = req_op[gnt_idx];
          alu_a  = req_a[gnt_idx];
          alu_b  = req_b[gnt_idx];
          if (MULT_HOLD && (req_op[gnt_idx] == MULT_OP)) begin
            state_d   = BUSY;
            cnt_d     = CNT_INIT;
            owner_d   = gnt_idx;
            lat_op_d  = req_op[gnt_idx];
            lat_a_d   = req_a[gnt_idx];
            lat_b_d   = req_b[gnt_idx];
            lat_tag_d = req_tag[gnt_idx];
          end else begin
            load[gnt_idx] = 1'b1;
            load_tag      = req_tag[gnt_idx];
          end
        end
      end
      BUSY: begin
        alu_op = lat_op_q;
        alu_a  = lat_a_q;
        alu_b  = lat_b_q;
        // The owner's slot was free at grant and cannot refill meanwhile.
        if (cnt_q == '0) begin
          load[owner_q] = 1'b1;
          load_tag      = lat_tag_q;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      lat_op_q  <= '0;
      lat_a_q   <= '0;
      lat_b_q   <= '0;
      lat_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      lat_op_q  <= lat_op_d;
      lat_a_q   <= lat_a_d;
      lat_b_q   <= lat_b_d;
      lat_tag_q <= lat_tag_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign req_ready[gi] = gnt_valid && (gnt_idx == 1'(gi));

      alu_rsp_slot #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
      ) u_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load[gi]),
        .out_i       (alu_out),
        .zero_i      (alu_zero),
        .tag_i       (load_tag),
        .rsp_ready_i (rsp_ready[gi]),
        .rsp_valid_o (rsp_valid[gi]),
        .rsp_out_o   (slot_out[gi]),
        .rsp_zero_o  (slot_zero[gi]),
        .rsp_tag_o   (slot_tag[gi]),
        .free_o      (slot_free[gi])
      );
    end
  endgenerate

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_out   = slot_out[0];
  assign rsp1_out   = slot_out[1];
  assign rsp0_zero  = slot_zero[0];
  assign rsp1_zero  = slot_zero[1];
  assign rsp0_tag   = slot_tag[0];
  assign rsp1_tag   = slot_tag[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached to the
// shared ALU port; expected values are hand-computed constants.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_tag, req1_tag;
  logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [31:0] rsp0_out, rsp1_out;
  logic [1:0]  rsp0_tag, rsp1_tag;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_zero;

  int n_checks = 0;
  int n_errors = 0;

  alu_share_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_tag   (req0_tag),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_out   (rsp0_out),
    .rsp0_zero  (rsp0_zero),
    .rsp0_tag   (rsp0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_tag   (req1_tag),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_out   (rsp1_out),
    .rsp1_zero  (rsp1_zero),
    .rsp1_tag   (rsp1_tag),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: slt is unsigned, unknown opcodes give zero.
  always_comb begin
    case (alu_op)
      OP_AND:  alu_out = alu_a & alu_b;
      OP_OR:   alu_out = alu_a | alu_b;
      OP_ADD:  alu_out = alu_a + alu_b;
      OP_SUB:  alu_out = alu_a - alu_b;
      OP_SLT:  alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
      OP_MULT: alu_out = alu_a * alu_b;
      OP_NOR:  alu_out = ~(alu_a | alu_b);
      OP_XOR:  alu_out = alu_a ^ alu_b;
      default: alu_out = 32'd0;
    endcase
    alu_zero = (alu_out == 32'd0);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] tag);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_tag = tag;
  endtask

  task automatic drive1(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] tag);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_tag = tag;
  endtask

  initial begin
    rst_n = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    drive0(1'b1, OP_SUB, 32'd9, 32'd9, 2'd0);
    drive1(1'b1, OP_OR, 32'd1, 32'd2, 2'd3);

    // Reset held with both requests active.
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("rst_req0_ready", req0_ready, 0);
      check_eq("rst_req1_ready", req1_ready, 0);
      check_eq("rst_rsp0_valid", rsp0_valid, 0);
      check_eq("rst_rsp1_valid", rsp1_valid, 0);
    end
    check_eq("rst_rsp0_out", rsp0_out, 0);
    check_eq("rst_rsp1_tag", rsp1_tag, 0);

    // Contention: port 0 must win first (rr_ptr=0), then alternate.
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("cont%0d_req0_ready", i), req0_ready, (i % 2) == 0);
      check_eq($sformatf("cont%0d_req1_ready", i), req1_ready, (i % 2) == 1);
      step();
      if ((i % 2) == 0) begin
        check_eq($sformatf("cont%0d_rsp0_valid", i), rsp0_valid, 1);
        check_eq($sformatf("cont%0d_rsp0_out", i), rsp0_out, 0);
        check_eq($sformatf("cont%0d_rsp0_zero", i), rsp0_zero, 1);
        check_eq($sformatf("cont%0d_rsp0_tag", i), rsp0_tag, 0);
      end else begin
        check_eq($sformatf("cont%0d_rsp1_valid", i), rsp1_valid, 1);
        check_eq($sformatf("cont%0d_rsp1_out", i), rsp1_out, 3);
        check_eq($sformatf("cont%0d_rsp1_zero", i), rsp1_zero, 0);
        check_eq($sformatf("cont%0d_rsp1_tag", i), rsp1_tag, 3);
      end
    end
    drive0(1'b0, OP_AND, 0, 0, 0);
    drive1(1'b0, OP_AND, 0, 0, 0);
    step();

    // Single ADD on port 0.
    drive0(1'b1, OP_ADD, 32'd5, 32'd7, 2'd1);
    #1;
    check_eq("add_req0_ready", req0_ready, 1);
    check_eq("add_req1_ready", req1_ready, 0);
    check_eq("add_alu_op", alu_op, OP_ADD);
    check_eq("add_alu_a", alu_a, 5);
    check_eq("add_alu_b", alu_b, 7);
    step();
    drive0(1'b0, OP_AND, 0, 0, 0);
    check_eq("add_rsp0_valid", rsp0_valid, 1);
    check_eq("add_rsp0_out", rsp0_out, 12);
    check_eq("add_rsp0_zero", rsp0_zero, 0);
    check_eq("add_rsp0_tag", rsp0_tag, 1);
    step();
    check_eq("add_rsp0_drained", rsp0_valid, 0);

    // MULT hold: port 1 stalls for two BUSY cycles.
    drive0(1'b1, OP_MULT, 32'h0001_0000, 32'h0001_0000, 2'd2);
    #1;
    check_eq("mult_req0_ready", req0_ready, 1);
    step();
    drive0(1'b0, OP_AND, 0, 0, 0);
    drive1(1'b1, OP_ADD, 32'd3, 32'd4, 2'd1);
    #1;
    check_eq("mult_busy1_req1_ready", req1_ready, 0);
    check_eq("mult_busy1_alu_op", alu_op, OP_MULT);
    check_eq("mult_busy1_rsp0_valid", rsp0_valid, 0);
    step();
    check_eq("mult_busy2_req1_ready", req1_ready, 0);
    check_eq("mult_busy2_rsp0_valid", rsp0_valid, 0);
    step();
    check_eq("mult_rsp0_valid", rsp0_valid, 1);
    check_eq("mult_rsp0_out", rsp0_out, 0);
    check_eq("mult_rsp0_zero", rsp0_zero, 1);
    check_eq("mult_rsp0_tag", rsp0_tag, 2);
    check_eq("mult_idle_req1_ready", req1_ready, 1);
    step();
    drive1(1'b0, OP_AND, 0, 0, 0);
    check_eq("mult_rsp1_valid", rsp1_valid, 1);
    check_eq("mult_rsp1_out", rsp1_out, 7);
    check_eq("mult_rsp1_tag", rsp1_tag, 1);
    step();

    // Backpressure on port 1.
    rsp1_ready = 1'b0;
    drive1(1'b1, OP_XOR, 32'd6, 32'd3, 2'd3);
    #1;
    check_eq("bp_fill_req1_ready", req1_ready, 1);
    step();
    drive1(1'b1, OP_ADD, 32'd1, 32'd1, 2'd0);
    #1;
    check_eq("bp_full_rsp1_valid", rsp1_valid, 1);
    check_eq("bp_full_rsp1_out", rsp1_out, 5);
    check_eq("bp_full_req1_ready", req1_ready, 0);
    step();
    check_eq("bp_hold_req1_ready", req1_ready, 0);
    check_eq("bp_hold_rsp1_valid", rsp1_valid, 1);
    check_eq("bp_hold_rsp1_out", rsp1_out, 5);
    check_eq("bp_hold_rsp1_tag", rsp1_tag, 3);
    rsp1_ready = 1'b1;
    #1;
    check_eq("bp_drain_req1_ready", req1_ready, 1);
    step();
    drive1(1'b0, OP_AND, 0, 0, 0);
    check_eq("bp_new_rsp1_valid", rsp1_valid, 1);
    check_eq("bp_new_rsp1_out", rsp1_out, 2);
    check_eq("bp_new_rsp1_zero", rsp1_zero, 0);
    check_eq("bp_new_rsp1_tag", rsp1_tag, 0);
    step();
    check_eq("bp_rsp1_drained", rsp1_valid, 0);

    // Reset during the second BUSY cycle discards the MULT.
    drive0(1'b1, OP_MULT, 32'h0001_0000, 32'd2, 2'd3);
    #1;
    check_eq("rmult_req0_ready", req0_ready, 1);
    step();
    drive0(1'b0, OP_AND, 0, 0, 0);
    check_eq("rmult_busy1_rsp0_valid", rsp0_valid, 0);
    step();
    rst_n = 1'b0;
    step();
    check_eq("rmult_rst_rsp0_valid", rsp0_valid, 0);
    rst_n = 1'b1;
    step();
    check_eq("rmult_post1_rsp0_valid", rsp0_valid, 0);
    step();
    check_eq("rmult_post2_rsp0_valid", rsp0_valid, 0);
    drive0(1'b1, OP_ADD, 32'd5, 32'd7, 2'd1);
    #1;
    check_eq("radd_req0_ready", req0_ready, 1);
    step();
    drive0(1'b0, OP_AND, 0, 0, 0);
    check_eq("radd_rsp0_valid", rsp0_valid, 1);
    check_eq("radd_rsp0_out", rsp0_out, 12);
    check_eq("radd_rsp0_tag", rsp0_tag, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters: port 0 is the EX stage, port 1 is the branch/address helper.
- Each port has a valid/ready request channel and a valid/ready response channel with a one-entry response buffer.
- Arbitration is round-robin. Multiply occupies the ALU for MULT_CYCLES cycles to meet multiplier timing.
- Sits between the pipeline and the ALU instance; the ALU itself stays external.

Parameters:
- DATA_W, 32, operand/result width
- OP_W, 4, ALU opcode width
- TAG_W, 2, requester-opaque tag returned with the result
- MULT_CYCLES, 3, cycles the ALU is held for opcode MULT (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- reqN_valid  in  1  request valid, N=0,1
- reqN_ready  out  1  request accepted this cycle when valid&ready
- reqN_op  in  OP_W  ALU opcode
- reqN_a, reqN_b  in  DATA_W  operands
- reqN_tag  in  TAG_W  tag
- rspN_valid  out  1  result available
- rspN_ready  in  1  consumer takes result
- rspN_out  out  DATA_W  result
- rspN_zero  out  1  ALU zero flag
- rspN_tag  out  TAG_W  echoed tag
- alu_op  out  OP_W  to shared ALU
- alu_a, alu_b  out  DATA_W  to shared ALU
- alu_out  in  DATA_W  from ALU
- alu_zero  in  1  from ALU

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low.
- Reset values: rspN_valid=0, rspN_out=0, rspN_zero=0, rspN_tag=0, rr_ptr=0, state=IDLE, counter=0.
- Eligibility: port N is eligible when reqN_valid and its slot is free. A slot is free when !rspN_valid or (rspN_valid & rspN_ready), i.e. same-cycle drain-and-refill is allowed.
- Grant rule:
  - Grants are issued only in IDLE, at most one per cycle.
  - If both ports are eligible, port rr_ptr wins; rr_ptr then becomes the other port.
  - If one port is eligible, it wins; rr_ptr then points to the loser.
  - reqN_ready is combinational: asserted only for the granted port.
- ALU drive:
  - In IDLE with a grant, the granted operands drive the ALU combinationally.
  - In BUSY, the latched operands drive the ALU.
  - Otherwise alu_op=4'b0000, alu_a=0, alu_b=0.
- FSM IDLE, non-MULT grant (or MULT with MULT_CYCLES=1):
  - alu_out, alu_zero and tag are captured into rspN at the edge; rspN_valid=1 next cycle. Latency is 1 cycle.
  - State stays IDLE.
- FSM IDLE, MULT grant with MULT_CYCLES>1:
  - Latch op, a, b, tag and owner; counter=MULT_CYCLES-2; go to BUSY.
- FSM BUSY:
  - No grants; both reqN_ready=0.
  - Counter decrements each cycle.
  - When counter==0, capture the ALU result into the owner's slot and return to IDLE.
  - Total latency from handshake to rsp_valid is MULT_CYCLES.
- Owner slot during BUSY: its slot was free at grant and cannot refill, so no overflow is possible. The other port's rsp may drain normally.
- Response hold: rspN_out, rspN_zero and rspN_tag stay stable while rspN_valid & !rspN_ready.
- Opcodes are passed through unchanged. An unknown opcode yields out=0, zero=1.
- Width: the result is truncated to DATA_W (low 32 bits of the product). The ALU's slt is unsigned and is passed through unmodified.
- Reset mid-operation: an in-flight MULT is discarded, buffered results are dropped, and the FSM returns to IDLE.
- Back-to-back: port N may issue every cycle if rspN_ready is held high and it keeps winning (other port idle).

Decomposition:
- Shared package alu_pkg:
  - ALU opcode constants: ADD=0010, AND=0000, MULT=1000, NOR=1100, OR=0001, SLT=0111, SUB=0110, XOR=1101.
  - DATA_W and OP_W.
  - An FSM state enum {IDLE, BUSY}.
- One natural sub-module, alu_rsp_slot: a one-entry valid/ready buffer holding out/zero/tag, instantiated twice.
- The arbiter FSM stays in the top level.

Test Plan:
- Reset: rst_n=0 for 2 cycles with reqs active -> all rsp_valid=0, req_ready=0 during reset; rr_ptr=0 afterwards.
- Single ADD on port 0: a=5, b=7 -> req0_ready same cycle; next cycle rsp0_valid=1, out=12, zero=0, tag echoed.
- Contention: both ports valid continuously (port0 SUB 9-9, port1 OR 1|2), rsp_ready=1 -> grants alternate 0,1,0,1; port0 out=0, zero=1; port1 out=3.
- MULT hold (MULT_CYCLES=3): port0 MULT 0x10000*0x10000, port1 ADD valid -> port1 stalled 2 cycles; rsp0 out=0, zero=1 exactly 3 cycles after handshake; port1 granted the cycle after return to IDLE.
- Backpressure: rsp1_ready=0 with rsp1 full and req1 ADD 1+1 pending -> req1_ready=0 and rsp1 held stable; raising rsp1_ready gives same-cycle drain and grant, new result 2 next cycle.
- Reset mid-MULT: assert rst_n=0 in BUSY cycle 2 -> no rsp0_valid ever produced for that op; first post-reset grant behaves as the single-ADD scenario.
